// File: rtl/subservient_wb_byte_bridge.sv
// Wishbone-to-byte-SRAM bridge for the subservient core's program memory.
// Each 32-bit Wishbone access is serialised into single-byte SRAM cycles.
// Writes emit only the selected lanes, in ascending order. Reads always
// fetch all four lanes and reassemble them into o_wb_rdt before ack.
module subservient_wb_byte_bridge #(
  parameter int AW = 13
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [31:0]   i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  input  logic [3:0]    i_wb_sel,
  input  logic          i_wb_we,
  input  logic          i_wb_stb,
  input  logic          i_wb_cyc,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  output logic [AW-1:0] o_sram_waddr,
  output logic [7:0]    o_sram_wdata,
  output logic          o_sram_wen,
  output logic [AW-1:0] o_sram_raddr,
  output logic          o_sram_ren,
  input  logic [7:0]    i_sram_rdata
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, ACK} state_t;

  state_t        state;
  logic [AW-3:0] word_q;
  logic [31:0]   dat_q;
  logic [3:0]    pend;
  logic [2:0]    rcnt;

  logic          req;
  logic [1:0]    lane_idle;
  logic [1:0]    lane_pend;
  logic [1:0]    cap_lane;
  logic [1:0]    next_lane;
  logic          unused_adr;

  // Lowest selected lane in a byte-enable mask.
  function automatic logic [1:0] first_lane(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // One-hot mask for a lane, used to retire it from the pending set.
  function automatic logic [3:0] lane_bit(input logic [1:0] k);
    return 4'b0001 << k;
  endfunction

  // Byte k of a 32-bit word.
  function automatic logic [7:0] byte_of(input logic [31:0] d, input logic [1:0] k);
    return d[{k, 3'b000} +: 8];
  endfunction

  assign req        = i_wb_stb & i_wb_cyc;
  assign lane_idle  = first_lane(i_wb_sel);
  assign lane_pend  = first_lane(pend);
  // Lane whose data returns this cycle: the one issued on the previous READ cycle.
  assign cap_lane   = rcnt[1:0] - 2'd1;
  assign next_lane  = rcnt[1:0] + 2'd1;
  // Byte offset and high address bits are intentionally ignored.
  assign unused_adr = ^{i_wb_adr[31:AW], i_wb_adr[1:0]};

  // Hold word address and write data for the lanes issued after the request cycle.
  always_ff @(posedge i_clk) begin
    if (state == IDLE && req) begin
      word_q <= i_wb_adr[AW-1:2];
      dat_q  <= i_wb_dat;
    end
  end

  // Transaction FSM; all SRAM and Wishbone outputs are registered here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      pend         <= '0;
      rcnt         <= '0;
      o_wb_rdt     <= '0;
      o_wb_ack     <= 1'b0;
      o_sram_waddr <= '0;
      o_sram_wdata <= '0;
      o_sram_wen   <= 1'b0;
      o_sram_raddr <= '0;
      o_sram_ren   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (i_wb_we) begin
              if (i_wb_sel == 4'b0000) begin
                // Nothing to write: acknowledge straight away.
                o_wb_ack <= 1'b1;
                state    <= ACK;
              end else begin
                o_sram_wen   <= 1'b1;
                o_sram_waddr <= {i_wb_adr[AW-1:2], lane_idle};
                o_sram_wdata <= byte_of(i_wb_dat, lane_idle);
                pend         <= i_wb_sel & ~lane_bit(lane_idle);
                state        <= WRITE;
              end
            end else begin
              o_sram_ren   <= 1'b1;
              o_sram_raddr <= {i_wb_adr[AW-1:2], 2'd0};
              rcnt         <= 3'd0;
              state        <= READ;
            end
          end
        end
        WRITE: begin
          if (pend != 4'b0000) begin
            o_sram_waddr <= {word_q, lane_pend};
            o_sram_wdata <= byte_of(dat_q, lane_pend);
            pend         <= pend & ~lane_bit(lane_pend);
          end else begin
            o_sram_wen <= 1'b0;
            o_wb_ack   <= 1'b1;
            state      <= ACK;
          end
        end
        READ: begin
          // rcnt 0..3 issue lanes 0..3; rcnt 1..4 capture lanes 0..3.
          if (rcnt != 3'd0) begin
            o_wb_rdt[{cap_lane, 3'b000} +: 8] <= i_sram_rdata;
          end
          if (rcnt < 3'd3) begin
            o_sram_raddr <= {word_q, next_lane};
          end else begin
            o_sram_ren <= 1'b0;
          end
          if (rcnt == 3'd4) begin
            o_wb_ack <= 1'b1;
            state    <= ACK;
          end
          rcnt <= rcnt + 3'd1;
        end
        ACK: begin
          o_wb_ack <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_subservient_wb_byte_bridge.sv
// Directed bench for subservient_wb_byte_bridge with a byte-wide SRAM model.
module tb_subservient_wb_byte_bridge;
  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [31:0]   wb_adr = '0;
  logic [31:0]   wb_dat = '0;
  logic [3:0]    wb_sel = '0;
  logic          wb_we = 1'b0;
  logic          wb_stb = 1'b0;
  logic          wb_cyc = 1'b0;
  logic [31:0]   rdt;
  logic          ack;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic          wen;
  logic [AW-1:0] raddr;
  logic          ren;
  logic [7:0]    rdata = '0;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;

  logic [7:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  subservient_wb_byte_bridge #(.AW(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_sel(wb_sel), .i_wb_we(wb_we),
    .i_wb_stb(wb_stb), .i_wb_cyc(wb_cyc),
    .o_wb_rdt(rdt), .o_wb_ack(ack),
    .o_sram_waddr(waddr), .o_sram_wdata(wdata), .o_sram_wen(wen),
    .o_sram_raddr(raddr), .o_sram_ren(ren), .i_sram_rdata(rdata)
  );

  // Byte SRAM: synchronous write, read data one cycle after ren.
  always @(posedge clk) begin
    if (wen) begin
      mem[waddr] <= wdata;
      wr_cnt     <= wr_cnt + 1;
    end
    if (ren) rdata <= mem[raddr];
  end

  // Present a request at a negedge; drop stb/cyc right after it is sampled.
  task automatic issue(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic w);
    wb_adr = a; wb_dat = d; wb_sel = s; wb_we = w; wb_stb = 1'b1; wb_cyc = 1'b1;
    @(posedge clk); #1;
    wb_stb = 1'b0; wb_cyc = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wb_adr = $urandom; wb_dat = $urandom; wb_sel = 4'($urandom);
      wb_we = 1'($urandom); wb_stb = 1'($urandom); wb_cyc = 1'($urandom);
      @(negedge clk);
      total++;
      if ({rdt, ack, waddr, wdata, wen, raddr, ren} !== '0) begin
        bad++;
        $display("FAIL reset_outputs: got rdt=%h ack=%b waddr=%h wdata=%h wen=%b raddr=%h ren=%b want all 0",
                 rdt, ack, waddr, wdata, wen, raddr, ren);
      end
    end
    wb_stb = 1'b0; wb_cyc = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({wen, ren, ack} !== 3'b000) begin
        bad++;
        $display("FAIL idle_after_reset: got wen/ren/ack=%b want 000", {wen, ren, ack});
      end
    end
  endtask

  task automatic test_full_write();
    logic [31:0] d;
    logic [23:0] exp;
    d = 32'hDEADBEEF;
    issue(32'h0000_0104, d, 4'hF, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp = {3'b100, 13'(32'h104 + k), d[8*k +: 8]};
      total++;
      if ({wen, ren, ack, waddr, wdata} !== exp) begin
        bad++;
        $display("FAIL full_write_lane%0d: got %h want %h", k, {wen, ren, ack, waddr, wdata}, exp);
      end
    end
    @(negedge clk);
    total++;
    if ({wen, ren, ack} !== 3'b001) begin
      bad++;
      $display("FAIL full_write_ack: got wen/ren/ack=%b want 001", {wen, ren, ack});
    end
    @(negedge clk);
    total++;
    if ({wen, ren, ack} !== 3'b000) begin
      bad++;
      $display("FAIL full_write_ack_single: got wen/ren/ack=%b want 000", {wen, ren, ack});
    end
    total++;
    if ({mem[13'h107], mem[13'h106], mem[13'h105], mem[13'h104]} !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL full_write_mem: got %h want deadbeef",
               {mem[13'h107], mem[13'h106], mem[13'h105], mem[13'h104]});
    end
  endtask

  task automatic test_sparse_write();
    int w0;
    w0 = wr_cnt;
    issue(32'h20, 32'h11223344, 4'b1010, 1'b1);
    @(negedge clk);
    total++;
    if ({wen, ren, ack, waddr, wdata} !== {3'b100, 13'h021, 8'h33}) begin
      bad++;
      $display("FAIL sparse_first: got %h want %h", {wen, ren, ack, waddr, wdata}, {3'b100, 13'h021, 8'h33});
    end
    @(negedge clk);
    total++;
    if ({wen, ren, ack, waddr, wdata} !== {3'b100, 13'h023, 8'h11}) begin
      bad++;
      $display("FAIL sparse_second: got %h want %h", {wen, ren, ack, waddr, wdata}, {3'b100, 13'h023, 8'h11});
    end
    @(negedge clk);
    total++;
    if ({wen, ren, ack} !== 3'b001) begin
      bad++;
      $display("FAIL sparse_ack: got wen/ren/ack=%b want 001", {wen, ren, ack});
    end
    @(negedge clk);
    total++;
    if (wr_cnt - w0 !== 2) begin
      bad++;
      $display("FAIL sparse_count: got %0d writes want 2", wr_cnt - w0);
    end
    // Empty byte mask: immediate ack, no SRAM traffic.
    w0 = wr_cnt;
    issue(32'h20, 32'hFFFFFFFF, 4'b0000, 1'b1);
    @(negedge clk);
    total++;
    if ({wen, ren, ack} !== 3'b001) begin
      bad++;
      $display("FAIL sel0_ack: got wen/ren/ack=%b want 001", {wen, ren, ack});
    end
    @(negedge clk);
    total++;
    if (wr_cnt - w0 !== 0 || ack !== 1'b0) begin
      bad++;
      $display("FAIL sel0_nowrite: got writes=%0d ack=%b want 0 0", wr_cnt - w0, ack);
    end
  endtask

  task automatic test_read_back();
    issue(32'h104, 32'h0, 4'b0001, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if ({wen, ren, ack, raddr} !== {3'b010, 13'(32'h104 + k)}) begin
        bad++;
        $display("FAIL read_lane%0d: got %h want %h", k, {wen, ren, ack, raddr}, {3'b010, 13'(32'h104 + k)});
      end
    end
    @(negedge clk);
    total++;
    if ({wen, ren, ack} !== 3'b000) begin
      bad++;
      $display("FAIL read_gap: got wen/ren/ack=%b want 000", {wen, ren, ack});
    end
    @(negedge clk);
    total++;
    if (ack !== 1'b1 || rdt !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL read_ack: got ack=%b rdt=%h want 1 deadbeef", ack, rdt);
    end
    @(negedge clk);
    // A write must leave the read register untouched.
    issue(32'h200, 32'h12345678, 4'hF, 1'b1);
    for (int i = 0; i < 6; i++) @(negedge clk);
    total++;
    if (rdt !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL rdt_hold: got %h want deadbeef", rdt);
    end
  endtask

  task automatic test_abort();
    int w0;
    int acks;
    w0 = wr_cnt;
    acks = 0;
    wb_adr = 32'h300; wb_dat = 32'hA1B2C3D4; wb_sel = 4'hF; wb_we = 1'b1;
    wb_stb = 1'b1; wb_cyc = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    wb_stb = 1'b0; wb_cyc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    total++;
    if (acks !== 1 || wr_cnt - w0 !== 4) begin
      bad++;
      $display("FAIL abort_complete: got acks=%0d writes=%0d want 1 4", acks, wr_cnt - w0);
    end
    total++;
    if ({mem[13'h303], mem[13'h302], mem[13'h301], mem[13'h300]} !== 32'hA1B2C3D4) begin
      bad++;
      $display("FAIL abort_mem: got %h want a1b2c3d4",
               {mem[13'h303], mem[13'h302], mem[13'h301], mem[13'h300]});
    end
  endtask

  task automatic test_reset_mid_write();
    issue(32'h400, 32'h0, 4'hF, 1'b1);
    for (int i = 0; i < 6; i++) @(negedge clk);
    issue(32'h400, 32'h55667788, 4'hF, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({rdt, ack, waddr, wdata, wen, raddr, ren} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: got rdt=%h ack=%b waddr=%h wdata=%h wen=%b raddr=%h ren=%b want all 0",
               rdt, ack, waddr, wdata, wen, raddr, ren);
    end
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if ({mem[13'h403], mem[13'h402], mem[13'h401], mem[13'h400]} !== 32'h00000088) begin
      bad++;
      $display("FAIL midreset_mem: got %h want 00000088",
               {mem[13'h403], mem[13'h402], mem[13'h401], mem[13'h400]});
    end
    issue(32'h400, 32'h0, 4'hF, 1'b0);
    for (int i = 0; i < 6; i++) @(negedge clk);
    total++;
    if (ack !== 1'b1 || rdt !== 32'h00000088) begin
      bad++;
      $display("FAIL midreset_next: got ack=%b rdt=%h want 1 00000088", ack, rdt);
    end
    @(negedge clk);
  endtask

  task automatic test_addr_mask();
    issue(32'hFFFF_E00C, 32'hCAFEF00D, 4'hF, 1'b1);
    @(negedge clk);
    total++;
    if ({wen, waddr, wdata} !== {1'b1, 13'h00C, 8'h0D}) begin
      bad++;
      $display("FAIL mask_waddr: got %h want %h", {wen, waddr, wdata}, {1'b1, 13'h00C, 8'h0D});
    end
    for (int i = 0; i < 5; i++) @(negedge clk);
    issue(32'hFFFF_E00C, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    total++;
    if ({ren, raddr} !== {1'b1, 13'h00C}) begin
      bad++;
      $display("FAIL mask_raddr: got %h want %h", {ren, raddr}, {1'b1, 13'h00C});
    end
    for (int i = 0; i < 5; i++) @(negedge clk);
    total++;
    if (ack !== 1'b1 || rdt !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL mask_read: got ack=%b rdt=%h want 1 cafef00d", ack, rdt);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_sparse_write();
    test_read_back();
    test_abort();
    test_reset_mid_write();
    test_addr_mask();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/subservient_wb_byte_bridge.md
# subservient_wb_byte_bridge

Wishbone-to-byte-SRAM bridge that sits directly upstream of the subservient core's byte-wide SRAM port. It lets the management Wishbone bus load and inspect program memory through the same byte interface the SRAM adapter consumes. Each 32-bit Wishbone access is split into sequential single-byte SRAM cycles. Read data is reassembled into a 32-bit word before the access is acknowledged.

## Interface
- `AW`, default 13: SRAM byte-address width.
- `i_clk`  in  1: sole clock; every flop is rising-edge.
- `i_rst_n`  in  1: asynchronous, active-low reset.
- `i_wb_adr`  in  32: byte address; bits [AW-1:2] select the word, bits [1:0] and bits [31:AW] are ignored.
- `i_wb_dat`  in  32: write data.
- `i_wb_sel`  in  4: byte-lane enables; bit k selects `i_wb_dat[8k+7:8k]`.
- `i_wb_we`  in  1: 1 means write, 0 means read.
- `i_wb_stb`, `i_wb_cyc`  in  1 each: a request is valid when both are high.
- `o_wb_rdt`  out  32: read data, registered.
- `o_wb_ack`  out  1: single-cycle acknowledge.
- `o_sram_waddr`  out  AW: byte write address.
- `o_sram_wdata`  out  8: byte write data.
- `o_sram_wen`  out  1: write strobe, one byte per cycle.
- `o_sram_raddr`  out  AW: byte read address.
- `o_sram_ren`  out  1: read strobe.
- `i_sram_rdata`  in  8: read data, valid exactly one cycle after `o_sram_ren`.

## Operation
- The FSM has four states: IDLE, WRITE, READ, ACK.
- IDLE, on `i_wb_stb & i_wb_cyc`:
  - latch the word address `i_wb_adr[AW-1:2]`, `i_wb_dat`, `i_wb_sel` and `i_wb_we`;
  - go to WRITE if the latched we is 1, else to READ.
- WRITE:
  - Emit one byte per cycle for each selected lane, in ascending lane order (0→3).
  - Unselected lanes are skipped with no idle cycles.
  - Each write cycle drives `o_sram_wen`=1, `o_sram_waddr`={word, k[1:0]}, `o_sram_wdata`=dat[8k+:8].
  - After the last selected lane, go to ACK.
  - If sel=0000, go to ACK immediately with no SRAM write.
- READ:
  - Always reads all four lanes; `i_wb_sel` is ignored.
  - Lane k is issued on READ cycle k (k=0..3): `o_sram_ren`=1, `o_sram_raddr`={word, k}.
  - `i_sram_rdata` is captured into `o_wb_rdt[8k+:8]` one cycle after lane k is issued.
  - After the lane-3 capture, go to ACK.
  - `o_wb_rdt` is updated only during read captures. It holds its value across writes and idle cycles.
- ACK: `o_wb_ack`=1 for exactly one cycle, then return to IDLE.
- `o_sram_wen` and `o_sram_ren` are never high in the same cycle.
- Outside active lane cycles, `o_sram_wen`/`o_sram_ren` are 0. Address and data outputs are then don't-care, but the implementation must not toggle them needlessly.
- Dropping stb/cyc mid-transaction does not abort it. Every remaining byte is still written or read, and ack still pulses.
- Requests arriving in any state other than IDLE are ignored; there is no queuing.
- Reset mid-operation:
  - all outputs go to 0 immediately and the FSM returns to IDLE;
  - bytes already written remain in SRAM; there is no rollback.
- Reset value of every output is 0, including `o_wb_rdt`.

## Timing
- Cycle 0 is the IDLE cycle in which the request is sampled.
- Write with n selected lanes (n=1..4): SRAM writes occur on cycles 1..n, and ack on cycle n+1.
- Write with n=0: ack on cycle 1.
- Read:
  - ren on cycles 1..4;
  - captures on the clock edges ending cycles 2..5;
  - ack on cycle 6, with `o_wb_rdt` fully valid while ack is high.
- The earliest next request is sampled the cycle after ack. This is compatible with a classic-cycle master that drops stb after ack.
- Throughput:
  - back-to-back full-word writes take 6 cycles each (sample, 4 writes, ack);
  - back-to-back reads take 7 cycles each (sample, 4 ren, 1 capture, ack).

## Test plan
- Reset: hold `i_rst_n`=0 with random inputs → all outputs 0. Release, then idle → no wen/ren, no ack.
- Full write: adr=0x0000_0104, dat=0xDEADBEEF, sel=1111, we=1 → wen on cycles 1–4 with (waddr, wdata) = (0x104, 0xEF), (0x105, 0xBE), (0x106, 0xAD), (0x107, 0xDE); ack on cycle 5.
- Sparse write: adr=0x20, dat=0x11223344, sel=1010 → exactly two writes: (0x21, 0x33) on cycle 1, then (0x23, 0x11) on cycle 2; ack on cycle 3. Then sel=0000 → no wen, ack on cycle 1.
- Read-back: SRAM model preloaded with bytes 0xEF, 0xBE, 0xAD, 0xDE at 0x104–0x107; read adr=0x104 with sel=0001 → ren with raddr 0x104–0x107 on cycles 1–4; ack on cycle 6 with `o_wb_rdt`=0xDEADBEEF; `o_wb_rdt` unchanged after a following write.
- Abort/reset: drop stb/cyc after cycle 1 of a full write → all 4 bytes still written and ack still pulses. In a second run, assert `i_rst_n`=0 during cycle 2 of a write → outputs 0 at once, only the lane-0 byte was written, and the next request is handled normally.
- Address masking: adr=0xFFFF_E00C (bits [31:AW] set) read → raddr starts at 0x00C; ack on cycle 6.
